spi_slave: RTL and testbench

//  SPI slave, mode 0, MSB first, with an active-low chip select.
//  It shifts serial frames in from MOSI and shows the last complete frame on a 4-bit LED register.
//  It also echoes the LED contents back on MISO during the next frame.
//  It sits at the board edge and is clocked directly by the master's serial clock.

---
 rtl/spi_slave.sv | 61 ++++++
 tb/tb_spi_slave.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// ============================================================================
// Module   : spi_slave
// Brief    : Mode-0 SPI slave, MSB first. Latches each complete frame onto
//            leds and echoes the previous leds value on MISO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave #(
    parameter int DATA_W = 4
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              MOSI,
    input  logic              CS,
    output logic              MISO,
    output logic [DATA_W-1:0] leds
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] r_rx_shift;
    logic [DATA_W-1:0] r_tx_shift;
    logic [DATA_W-1:0] r_leds;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] w_rx_next;

    assign w_rx_next = {r_rx_shift[DATA_W-2:0], MOSI};

    // CS high is the idle state, CS low the shift state; the sampled CS
    // selects the branch directly, so the edge that first sees CS low already
    // captures a data bit.
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_leds     <= '0;
            r_bit_cnt  <= '0;
        end else if (CS) begin
            r_bit_cnt  <= '0;
            r_tx_shift <= r_leds;
        end else begin
            r_rx_shift <= w_rx_next;
            if (r_bit_cnt == c_last_bit) begin
                r_leds     <= w_rx_next;
                r_tx_shift <= w_rx_next;
                r_bit_cnt  <= '0;
            end else begin
                r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
            end
        end
    end

    assign MISO = CS ? 1'b0 : r_tx_shift[DATA_W-1];
    assign leds = r_leds;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
// ============================================================================
// Module   : tb_spi_slave
// Brief    : Directed vector table for spi_slave plus a CS/MOSI glitch sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave;

    localparam int DATA_W = 4;

    logic              sclk = 1'b0;
    logic              rst  = 1'b1;
    logic              MOSI = 1'b0;
    logic              CS   = 1'b1;
    logic              MISO;
    logic [DATA_W-1:0] leds;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              rst;
        logic              cs;
        logic              mosi;
        logic              exp_miso;   // MISO just before the edge
        logic [DATA_W-1:0] exp_leds;   // leds just after the edge
        string             name;
    } vec_t;

    vec_t vecs[$];

    spi_slave #(.DATA_W(DATA_W)) dut (
        .sclk (sclk),
        .rst  (rst),
        .MOSI (MOSI),
        .CS   (CS),
        .MISO (MISO),
        .leds (leds)
    );

    always #5 sclk = ~sclk;

    task automatic add(input logic r, input logic c, input logic m,
                       input logic em, input logic [DATA_W-1:0] el, input string n);
        vec_t v;
        v.rst = r; v.cs = c; v.mosi = m; v.exp_miso = em; v.exp_leds = el; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic check_miso(input logic exp, input string n);
        checks++;
        if (MISO !== exp) begin
            errors++;
            $display("FAIL %s miso: got %b expected %b", n, MISO, exp);
        end
    endtask

    task automatic check_leds(input logic [DATA_W-1:0] exp, input string n);
        checks++;
        if (leds !== exp) begin
            errors++;
            $display("FAIL %s leds: got %b expected %b", n, leds, exp);
        end
    endtask

    initial begin
        // reset held for four edges
        for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 4'b0000, "reset");
        // first frame 1011: leds change only on the 4th edge, MISO echoes zeros
        add(0, 0, 1, 0, 4'b0000, "f1011_b0");
        add(0, 0, 0, 0, 4'b0000, "f1011_b1");
        add(0, 0, 1, 0, 4'b0000, "f1011_b2");
        add(0, 0, 1, 0, 4'b1011, "f1011_b3");
        // idle edge loads tx from leds; MOSI ignored
        add(0, 1, 1, 0, 4'b1011, "idle");
        // frame 0001 while MISO echoes 1,0,1,1
        add(0, 0, 0, 1, 4'b1011, "f0001_b0");
        add(0, 0, 0, 0, 4'b1011, "f0001_b1");
        add(0, 0, 0, 1, 4'b1011, "f0001_b2");
        add(0, 0, 1, 1, 4'b0001, "f0001_b3");
        // back-to-back 1100_0011 with no idle edge
        add(0, 0, 1, 0, 4'b0001, "b2b_b0");
        add(0, 0, 1, 0, 4'b0001, "b2b_b1");
        add(0, 0, 0, 0, 4'b0001, "b2b_b2");
        add(0, 0, 0, 1, 4'b1100, "b2b_b3");
        add(0, 0, 0, 1, 4'b1100, "b2b_b4");
        add(0, 0, 0, 1, 4'b1100, "b2b_b5");
        add(0, 0, 1, 0, 4'b1100, "b2b_b6");
        add(0, 0, 1, 0, 4'b0011, "b2b_b7");
        // reset, then aborted frame 101 followed by full frame 0110
        add(1, 1, 0, 0, 4'b0000, "rst2");
        add(0, 0, 1, 0, 4'b0000, "abort_b0");
        add(0, 0, 0, 0, 4'b0000, "abort_b1");
        add(0, 0, 1, 0, 4'b0000, "abort_b2");
        add(0, 1, 1, 0, 4'b0000, "abort_cs");
        add(0, 0, 0, 0, 4'b0000, "f0110_b0");
        add(0, 0, 1, 0, 4'b0000, "f0110_b1");
        add(0, 0, 1, 0, 4'b0000, "f0110_b2");
        add(0, 0, 0, 0, 4'b0110, "f0110_b3");
        // reset two bits into a frame, then frame 1001 decoded from bit 0
        add(0, 0, 1, 0, 4'b0110, "pre_rst_b0");
        add(0, 0, 1, 1, 4'b0110, "pre_rst_b1");
        add(1, 0, 1, 1, 4'b0000, "mid_rst");
        add(0, 0, 1, 0, 4'b0000, "f1001_b0");
        add(0, 0, 0, 0, 4'b0000, "f1001_b1");
        add(0, 0, 0, 0, 4'b0000, "f1001_b2");
        add(0, 0, 1, 0, 4'b1001, "f1001_b3");

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge sclk);
            rst  = vecs[i].rst;
            CS   = vecs[i].cs;
            MOSI = vecs[i].mosi;
            #1;
            check_miso(vecs[i].exp_miso, vecs[i].name);
            @(posedge sclk);
            #1;
            check_leds(vecs[i].exp_leds, vecs[i].name);
        end

        // CS and MOSI glitch between edges: only the values at the edge count.
        // Frame 1010 follows 1001 back-to-back, so MISO echoes 1,0,0,1.
        begin
            logic [DATA_W-1:0] frame;
            logic [DATA_W-1:0] echo;
            frame = 4'b1010;
            echo  = 4'b1001;
            for (int b = DATA_W - 1; b >= 0; b--) begin
                @(negedge sclk);
                CS   = 1'b1;
                MOSI = ~frame[b];
                #1;
                CS   = 1'b0;
                MOSI = frame[b];
                #1;
                check_miso(echo[b], "glitch");
                @(posedge sclk);
                #2;
                CS   = 1'b1;
                MOSI = ~frame[b];
                #1;
                CS   = 1'b0;
                if (b != 0) check_leds(4'b1001, "glitch_hold");
            end
            #1;
            check_leds(4'b1010, "glitch_frame");
        end

        @(negedge sclk);
        CS = 1'b1;
        #1;
        check_miso(1'b0, "cs_high_miso");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
